// File: rtl/wb_bus_master.sv
// wb_bus_master: single-transfer Wishbone classic initiator for the CPU memory stage (optional watchdog via WB_TIMEOUT_EN)
module wb_bus_master #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_done_o,
  output logic        cpu_err_o,
  output logic        cpu_stall_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_bus_master: TIMEOUT_CYCLES out of range 2..65535");
  end
  logic [1:0] state;
  logic       tmo;
`ifdef WB_TIMEOUT_EN
  logic [15:0] cnt;
  assign tmo = cnt == 16'(TIMEOUT_CYCLES - 1);
  // watchdog: zero outside BUS, counts BUS cycles that see neither ack nor err
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state != BUS) cnt <= '0;
    else if (!wb_ack_i && !wb_err_i) cnt <= cnt + 16'd1;
  end
`else
  assign tmo = 1'b0;
`endif
  assign cpu_stall_o = (state == IDLE && cpu_req_i) || state == BUS;
  // transfer FSM: launch in IDLE, wait for ack/err (or watchdog) in BUS, one-cycle turnaround in DONE
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      wb_we_o     <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_cyc_o    <= 1'b0;
      cpu_rdata_o <= '0;
      cpu_done_o  <= 1'b0;
      cpu_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cpu_req_i) begin
          wb_adr_o <= cpu_addr_i;
          wb_dat_o <= cpu_wdata_i;
          wb_sel_o <= cpu_sel_i;
          wb_we_o  <= cpu_we_i;
          wb_stb_o <= 1'b1;
          wb_cyc_o <= 1'b1;
          state    <= BUS;
        end
        BUS: if (wb_err_i || wb_ack_i || tmo) begin
          cpu_rdata_o <= (wb_err_i || !wb_ack_i || wb_we_o) ? 32'd0 : wb_dat_i;
          cpu_err_o   <= wb_err_i || !wb_ack_i;
          cpu_done_o  <= 1'b1;
          wb_stb_o    <= 1'b0;
          wb_cyc_o    <= 1'b0;
          state       <= DONE;
        end
        DONE: begin
          cpu_done_o <= 1'b0;
          cpu_err_o  <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_bus_master.sv
// tb_wb_bus_master: directed self-checking bench for wb_bus_master
module tb_wb_bus_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0, dat_i = '0;
  logic [3:0]  sel = '0;
  logic        ack = 1'b0, err = 1'b0;
  logic [31:0] rdata, adr, dat_o;
  logic        done, cerr, stall, wb_we, stb, cyc;
  logic [3:0]  wb_sel;
  int          n_cmp = 0, n_bad = 0;

  wb_bus_master #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cpu_req_i(req), .cpu_we_i(we), .cpu_addr_i(addr), .cpu_wdata_i(wdata), .cpu_sel_i(sel),
    .cpu_rdata_o(rdata), .cpu_done_o(done), .cpu_err_o(cerr), .cpu_stall_o(stall),
    .wb_adr_o(adr), .wb_dat_o(dat_o), .wb_dat_i(dat_i), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
    .wb_stb_o(stb), .wb_cyc_o(cyc), .wb_ack_i(ack), .wb_err_i(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int bad;
    tick(); tick();
    chk("rst_cyc", {31'd0, cyc}, 32'd0);
    chk("rst_stb", {31'd0, stb}, 32'd0);
    chk("rst_adr", adr, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, cerr}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    tick();
    // load with ack on the second strobe cycle
    req = 1'b1; we = 1'b0; addr = 32'h0200_BFF8; sel = 4'hF; #1;
    chk("ld_stall_idle", {31'd0, stall}, 32'd1);
    tick();
    chk("ld_cyc1", {30'd0, cyc, stb}, 32'd3);
    chk("ld_adr", adr, 32'h0200_BFF8);
    chk("ld_we", {31'd0, wb_we}, 32'd0);
    chk("ld_stall1", {31'd0, stall}, 32'd1);
    tick();
    chk("ld_cyc2", {30'd0, cyc, stb}, 32'd3);
    chk("ld_stall2", {31'd0, stall}, 32'd1);
    chk("ld_nodone", {31'd0, done}, 32'd0);
    ack = 1'b1; dat_i = 32'h1234_5678;
    tick();
    chk("ld_done", {31'd0, done}, 32'd1);
    chk("ld_rdata", rdata, 32'h1234_5678);
    chk("ld_err", {31'd0, cerr}, 32'd0);
    chk("ld_cyc_done", {30'd0, cyc, stb}, 32'd0);
    chk("ld_stall_done", {31'd0, stall}, 32'd0);
    req = 1'b0; ack = 1'b0;
    tick();
    chk("ld_done_clr", {31'd0, done}, 32'd0);
    chk("ld_rdata_hold", rdata, 32'h1234_5678);
    // store with a stale ack lingering into DONE
    req = 1'b1; we = 1'b1; addr = 32'h0200_0000; wdata = 32'h0000_0001; sel = 4'hF;
    tick();
    chk("st_cyc", {30'd0, cyc, stb}, 32'd3);
    chk("st_dat", dat_o, 32'h0000_0001);
    chk("st_we", {31'd0, wb_we}, 32'd1);
    chk("st_sel", {28'd0, wb_sel}, 32'hF);
    chk("st_adr", adr, 32'h0200_0000);
    ack = 1'b1;
    tick();
    chk("st_done", {31'd0, done}, 32'd1);
    chk("st_rdata0", rdata, 32'd0);
    chk("st_err", {31'd0, cerr}, 32'd0);
    chk("st_cyc_done", {31'd0, cyc}, 32'd0);
    req = 1'b0;
    tick();
    chk("st_stale_done", {31'd0, done}, 32'd0);
    chk("st_stale_cyc", {31'd0, cyc}, 32'd0);
    ack = 1'b0;
    tick();
    chk("st_idle_done", {31'd0, done}, 32'd0);
    // back-to-back loads with req held high
    req = 1'b1; we = 1'b0; addr = 32'h0000_0010;
    tick();
    chk("b2b_cyc1", {31'd0, cyc}, 32'd1);
    ack = 1'b1; dat_i = 32'hAAAA_5555;
    tick();
    chk("b2b_done1", {31'd0, done}, 32'd1);
    chk("b2b_rdata1", rdata, 32'hAAAA_5555);
    chk("b2b_cyc_done", {31'd0, cyc}, 32'd0);
    ack = 1'b0; addr = 32'h0000_0014;
    tick();
    chk("b2b_gap_cyc", {31'd0, cyc}, 32'd0);
    chk("b2b_gap_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("b2b_stb2", {31'd0, stb}, 32'd1);
    chk("b2b_adr2", adr, 32'h0000_0014);
    ack = 1'b1; dat_i = 32'h0BAD_F00D;
    tick();
    chk("b2b_done2", {31'd0, done}, 32'd1);
    chk("b2b_rdata2", rdata, 32'h0BAD_F00D);
    req = 1'b0; ack = 1'b0;
    tick();
    // ack and err together: err wins
    req = 1'b1; addr = 32'h0000_0020;
    tick();
    ack = 1'b1; err = 1'b1; dat_i = 32'hFFFF_FFFF;
    tick();
    chk("ae_done", {31'd0, done}, 32'd1);
    chk("ae_err", {31'd0, cerr}, 32'd1);
    chk("ae_rdata", rdata, 32'd0);
    req = 1'b0; ack = 1'b0; err = 1'b0;
    tick();
    chk("ae_err_clr", {31'd0, cerr}, 32'd0);
    // reset during the third wait cycle
    req = 1'b1; addr = 32'h0000_0040;
    tick(); tick(); tick();
    chk("rm_cyc_w3", {31'd0, cyc}, 32'd1);
    rst = 1'b1;
    tick();
    chk("rm_cyc", {30'd0, cyc, stb}, 32'd0);
    chk("rm_done", {31'd0, done}, 32'd0);
    chk("rm_idle_stall", {31'd0, stall}, 32'd1);
    rst = 1'b0;
    tick();
    chk("rm_restart_cyc", {31'd0, cyc}, 32'd1);
    ack = 1'b1; dat_i = 32'hCAFE_BABE;
    tick();
    chk("rm_done2", {31'd0, done}, 32'd1);
    chk("rm_rdata", rdata, 32'hCAFE_BABE);
    chk("rm_err", {31'd0, cerr}, 32'd0);
    req = 1'b0; ack = 1'b0;
    tick();
    // silent target
    req = 1'b1; addr = 32'h0000_0030;
    tick();
`ifdef WB_TIMEOUT_EN
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (cyc !== 1'b1 || done !== 1'b0) bad++;
      tick();
    end
    chk("to_wait_cycles", bad, 32'd0);
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_err", {31'd0, cerr}, 32'd1);
    chk("to_rdata", rdata, 32'd0);
    chk("to_cyc", {31'd0, cyc}, 32'd0);
`else
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (cyc !== 1'b1 || done !== 1'b0) bad++;
      tick();
    end
    chk("nto_hang", bad, 32'd0);
    chk("nto_rdata_hold", rdata, 32'hCAFE_BABE);
`endif
    req = 1'b0; rst = 1'b1;
    tick();
    chk("end_cyc", {31'd0, cyc}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
